// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side controller for the 16-bit, 8-deep synchronous
// FIFO (1-cycle read latency). It issues fifo_r_en, captures fifo_data one
// cycle later into a 2-entry prefetch buffer, and presents the words as a
// valid/ready stream. The buffer holds back-pressure for one word per cycle
// without losing data.
// Optional feature: define STREAM_RD_COUNT_EN to add the rd_count port, which
// counts delivered words.
module fifo_stream_reader #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_r_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy
`ifdef STREAM_RD_COUNT_EN
  ,
  output logic [CNT_W-1:0]  rd_count
`endif
);

  // Buffer storage and bookkeeping.
  logic [DATA_W-1:0] entry_q [2];
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;

  logic              pop;
  logic              capture;
  logic [2:0]        level;

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = entry_q[head_q];
  assign busy    = m_valid | inflight_q;
  assign pop     = m_valid & m_ready;

  // A read is in flight whenever inflight_q is set. A flush discards that word
  // instead of writing it into the buffer.
  assign capture = inflight_q & ~flush;

  // Occupancy the buffer will have after this edge, before counting a new read.
  // The buffer can hold at most 2 words, so a new read is allowed only below 2.
  // A pop requires occ >= 1, so this subtraction never underflows.
  assign level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

  // Read request. It is combinational so that a pop in this cycle frees its
  // slot for a read in the same cycle.
  assign fifo_r_en = en & ~fifo_empty & ~flush & ~rst & (level < 3'd2);

  // Next-state logic for the pointers, the occupancy and the in-flight flag.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves a signal
    // unassigned and no latch is inferred.
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    inflight_d = inflight_q;
    if (flush) begin
      head_d     = 1'b0;
      tail_d     = 1'b0;
      occ_d      = 2'd0;
      inflight_d = 1'b0;
    end else begin
      head_d     = head_q ^ pop;
      tail_d     = tail_q ^ capture;
      occ_d      = level[1:0];
      inflight_d = fifo_r_en;
    end
  end

  // State register. The incoming word is written into the tail entry.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // here samples values from before this edge.
    if (rst) begin
      // NOTE: the data entries are also cleared on reset, so m_data reads as
      // zero afterwards. Without that, the storage would need no reset at all.
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      if (capture) begin
        entry_q[tail_q] <= fifo_data;
      end
    end
  end

`ifdef STREAM_RD_COUNT_EN
  logic [CNT_W-1:0] rd_count_q;

  assign rd_count = rd_count_q;

  // Delivered-word counter. It wraps around, and it restarts on flush while
  // still counting a pop that happens in the flush cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_q <= '0;
    end else if (flush) begin
      rd_count_q <= CNT_W'(pop);
    end else if (pop) begin
      rd_count_q <= rd_count_q + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed bench for fifo_stream_reader. It contains a
// behavioural model of the 8-deep, 1-cycle-latency FIFO. Delivered words are
// collected on the falling edge and compared against hand-computed sequences.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic        fifo_empty;
  logic [15:0] fifo_data = '0;
  logic        fifo_r_en;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic        busy;
`ifdef STREAM_RD_COUNT_EN
  logic [15:0] rd_count;
`endif

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_W(16), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy)
`ifdef STREAM_RD_COUNT_EN
    ,
    .rd_count   (rd_count)
`endif
  );

  // Behavioural source FIFO: 8 deep, data_out registered on a read.
  logic [15:0] f_mem [8];
  logic [2:0]  f_wp, f_rp;
  logic [3:0]  f_cnt;
  logic        f_wr = 1'b0;
  logic        f_clr = 1'b1;
  logic [15:0] f_din = '0;

  assign fifo_empty = (f_cnt == 4'd0);

  always @(posedge clk) begin
    if (f_clr) begin
      f_wp  <= '0;
      f_rp  <= '0;
      f_cnt <= '0;
    end else begin
      if (f_wr && (f_cnt != 4'd8)) begin
        f_mem[f_wp] <= f_din;
        f_wp        <= f_wp + 3'd1;
      end
      if (fifo_r_en && (f_cnt != 4'd0)) begin
        fifo_data <= f_mem[f_rp];
        f_rp      <= f_rp + 3'd1;
      end
      f_cnt <= f_cnt + 4'((f_wr && (f_cnt != 4'd8)) ? 1 : 0)
                     - 4'((fifo_r_en && (f_cnt != 4'd0)) ? 1 : 0);
    end
  end

  // Monitors: collect delivered words, count reads, and flag protocol slips.
  int          cyc = 0;
  logic [15:0] got [$];
  int          pop_cyc [$];
  int          rd_cnt = 0;
  int          empty_rd = 0;
  int          unstable = 0;
  logic        hold_prev = 1'b0;
  logic        rst_prev = 1'b0;
  logic        flush_prev = 1'b0;
  logic [15:0] hold_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      got.push_back(m_data);
      pop_cyc.push_back(cyc);
    end
    if (fifo_r_en) rd_cnt++;
    if (fifo_r_en && fifo_empty) empty_rd++;
    if (hold_prev && !rst_prev && !flush_prev && (!m_valid || m_data !== hold_data))
      unstable++;
    hold_prev  = m_valid && !m_ready;
    hold_data  = m_data;
    rst_prev   = rst;
    flush_prev = flush;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dut_reset();
    rst = 1'b1; en = 1'b0; flush = 1'b0; m_ready = 1'b0; f_wr = 1'b0; f_clr = 1'b1;
    tick();
    rst = 1'b0; f_clr = 1'b0;
    got.delete();
    pop_cyc.delete();
  endtask

  task automatic preload(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      f_wr  = 1'b1;
      f_din = base + 16'(i);
      tick();
    end
    f_wr = 1'b0;
  endtask

  initial begin
    // Reset state, with the FIFO full and en=1 applied during reset.
    dut_reset();
    preload(8, 16'h0001);
    rst = 1'b1; en = 1'b1; m_ready = 1'b1;
    #1 check("rst_ren", fifo_r_en, 0);
    tick();
    rst = 1'b0;
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_busy", busy, 0);
    got.delete();
    pop_cyc.delete();

    // Stream 8 words: reads on k=0..7, words 1..8 visible on k=2..9.
    for (int k = 0; k < 12; k++) begin
      #1;
      check($sformatf("s1_ren%0d", k), fifo_r_en, (k < 8));
      check($sformatf("s1_val%0d", k), m_valid, (k >= 2 && k <= 9));
      if (k >= 2 && k <= 9) check($sformatf("s1_dat%0d", k), m_data, k - 1);
      if (k >= 10) check($sformatf("s1_busy%0d", k), busy, 0);
      tick();
    end
    check("s1_n", got.size(), 8);
`ifdef STREAM_RD_COUNT_EN
    check("s1_cnt", rd_count, 8);
`endif

    // Back-pressure: only 2 reads issue, and word 1 is held until release.
    dut_reset();
    preload(8, 16'h0001);
    rd_cnt = 0;
    en = 1'b1; m_ready = 1'b0;
    repeat (10) tick();
    check("bp_reads", rd_cnt, 2);
    check("bp_valid", m_valid, 1);
    check("bp_hold", m_data, 16'h0001);
    check("bp_fcnt", f_cnt, 6);
    m_ready = 1'b1;
    repeat (12) tick();
    check("bp_n", got.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < got.size()) check($sformatf("bp_w%0d", i), got[i], i + 1);
    if (pop_cyc.size() == 8) check("bp_gap", pop_cyc[7] - pop_cyc[0], 7);
    check("bp_stable", unstable, 0);

    // Alternating m_ready. The producer writes 16 words mid-stream, so the
    // FIFO pointers wrap and the FIFO runs empty several times.
    dut_reset();
    en = 1'b1;
    begin
      int wi;
      wi = 0;
      for (int k = 0; k < 90; k++) begin
        m_ready = (k % 2 == 0);
        f_wr    = (wi < 16) && (f_cnt < 4'd7) && (k % 5 != 4) && (k >= 3);
        f_din   = 16'h0100 + 16'(wi);
        if (f_wr) wi++;
        tick();
      end
      f_wr = 1'b0;
    end
    check("alt_n", got.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < got.size()) check($sformatf("alt_w%0d", i), got[i], 16'h0100 + i);
    check("alt_empty_rd", empty_rd, 0);
    check("alt_stable", unstable, 0);

    // en dropped after 3 reads: exactly 3 delivered, 5 left in the FIFO.
    dut_reset();
    preload(8, 16'h0001);
    rd_cnt = 0;
    m_ready = 1'b1; en = 1'b1;
    repeat (3) tick();
    en = 1'b0;
    repeat (10) tick();
    check("en_reads", rd_cnt, 3);
    check("en_n", got.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < got.size()) check($sformatf("en_w%0d", i), got[i], i + 1);
    check("en_busy", busy, 0);
    check("en_fcnt", f_cnt, 5);

    // Flush with a full buffer: words 1,2 are dropped, and streaming resumes at 3.
    dut_reset();
    preload(8, 16'h0001);
    en = 1'b1; m_ready = 1'b0;
    repeat (4) tick();
    check("fl2_full", m_valid, 1);
    flush = 1'b1;
    #1 check("fl2_ren", fifo_r_en, 0);
    tick();
    flush = 1'b0;
    check("fl2_valid", m_valid, 0);
    check("fl2_busy", busy, 0);
    m_ready = 1'b1;
    repeat (12) tick();
    check("fl2_n", got.size(), 6);
    if (got.size() == 6) begin
      check("fl2_first", got[0], 16'h0003);
      check("fl2_last", got[5], 16'h0008);
    end
`ifdef STREAM_RD_COUNT_EN
    check("fl2_cnt", rd_count, 6);
`endif

    // Flush while a read is in flight and a pop happens in the same cycle:
    // word 2 is delivered, word 3 is dropped, and word 4 comes next.
    dut_reset();
    preload(8, 16'h0001);
    en = 1'b1; m_ready = 1'b1;
    repeat (3) tick();
    flush = 1'b1;
    #1;
    check("fl1_ren", fifo_r_en, 0);
    check("fl1_pop", m_data, 16'h0002);
    tick();
    flush = 1'b0;
    check("fl1_valid", m_valid, 0);
    check("fl1_busy", busy, 0);
`ifdef STREAM_RD_COUNT_EN
    check("fl1_cnt", rd_count, 1);
`endif
    repeat (12) tick();
    check("fl1_n", got.size(), 7);
    if (got.size() == 7) begin
      check("fl1_w1", got[1], 16'h0002);
      check("fl1_w2", got[2], 16'h0004);
      check("fl1_w6", got[6], 16'h0008);
    end

    // Reset while the stream is stalled: everything clears to zero.
    dut_reset();
    preload(8, 16'h0001);
    en = 1'b1; m_ready = 1'b0;
    repeat (4) tick();
    check("mr_pre", m_data, 16'h0001);
    rst = 1'b1;
    #1 check("mr_ren", fifo_r_en, 0);
    tick();
    check("mr_valid", m_valid, 0);
    check("mr_data", m_data, 0);
    check("mr_busy", busy, 0);
`ifdef STREAM_RD_COUNT_EN
    check("mr_cnt", rd_count, 0);
`endif
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
